// File: rtl/call_stack_ctrl.sv
// Push/pop sequencer and arbiter for the 16-entry hardware call stack.
// Optional STACK_TRAP_EN: refuse overflow/underflow and raise sticky error flags.
module call_stack_ctrl #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq_req,
    input  logic [DATA_W-1:0] irq_pc,
    input  logic              call_req,
    input  logic [DATA_W-1:0] call_pc,
    input  logic              ret_req,
    output logic              irq_ack,
    output logic              call_ack,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_addr,
    output logic              stall,
    output logic [4:0]        depth,
    output logic              stk_rst,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    input  logic              err_clr,
    output logic              ovf_err,
    output logic              unf_err
);

    typedef enum logic [1:0] {IDLE, GAP, RDATA} state_t;

    localparam logic [4:0] FULL_LVL = 5'(DEPTH);

    state_t            state_q, state_d;
    logic [4:0]        depth_q, depth_d;
    logic              stk_rst_q;
    logic              ret_valid_q, ret_valid_d;
    logic [DATA_W-1:0] ret_addr_q, ret_addr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              zero_q, zero_d;

    logic              full;
    logic              empty;
    logic              push_req;
    logic              ret_ok;
    logic [DATA_W-1:0] push_pc;

    assign full     = (depth_q == FULL_LVL);
    assign empty    = (depth_q == 5'd0);
    assign push_req = irq_req | call_req;
    assign push_pc  = irq_req ? irq_pc : call_pc;
    // the ret_valid cycle still sees the old ret_req; it must not re-pop
    assign ret_ok   = ret_req & ~ret_valid_q & (state_q == IDLE);

`ifndef STACK_TRAP_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        ret_valid_d = 1'b0;
        ret_addr_d  = ret_addr_q;
        zero_d      = 1'b0;
        irq_ack     = 1'b0;
        call_ack    = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_din     = '0;
`ifdef STACK_TRAP_EN
        ovf_d       = ovf_q & ~err_clr;
        unf_d       = unf_q & ~err_clr;
`else
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
`endif
        if (!stk_rst_q) begin
            unique case (state_q)
                IDLE, GAP: begin
                    if (push_req) begin
                        irq_ack  = irq_req;
                        call_ack = ~irq_req;
`ifdef STACK_TRAP_EN
                        if (full) begin
                            ovf_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stk_push = 1'b1;
                            stk_din  = push_pc;
                            depth_d  = depth_q + 5'd1;
                            state_d  = GAP;
                        end
`else
                        stk_push = 1'b1;
                        stk_din  = push_pc;
                        state_d  = GAP;
                        if (!full) depth_d = depth_q + 5'd1;
`endif
                    end else if (ret_ok) begin
`ifdef STACK_TRAP_EN
                        if (empty) begin
                            unf_d  = 1'b1;
                            zero_d = 1'b1;
                        end else begin
                            stk_pop = 1'b1;
                            depth_d = depth_q - 5'd1;
                        end
`else
                        stk_pop = 1'b1;
                        if (!empty) depth_d = depth_q - 5'd1;
`endif
                        state_d = RDATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RDATA: begin
                    ret_valid_d = 1'b1;
                    ret_addr_d  = zero_q ? '0 : stk_dout;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            depth_q     <= 5'd0;
            stk_rst_q   <= 1'b1;
            ret_valid_q <= 1'b0;
            ret_addr_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            stk_rst_q   <= 1'b0;
            ret_valid_q <= ret_valid_d;
            ret_addr_q  <= ret_addr_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
        end
    end

    assign stall = (irq_req & ~irq_ack)
                 | (call_req & ~call_ack)
                 | (ret_req & ~ret_valid_q);

    assign ret_valid = ret_valid_q;
    assign ret_addr  = ret_addr_q;
    assign depth     = depth_q;
    assign stk_rst   = stk_rst_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl with a behavioural call_stack model.
// Builds with or without STACK_TRAP_EN.
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_req, call_req, ret_req, err_clr;
    logic [15:0] irq_pc, call_pc;
    logic        irq_ack, call_ack, ret_valid, stall;
    logic [15:0] ret_addr, stk_din, stk_dout;
    logic [4:0]  depth;
    logic        stk_rst, stk_push, stk_pop, ovf_err, unf_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    call_stack_ctrl #(.DEPTH(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .irq_req(irq_req), .irq_pc(irq_pc),
        .call_req(call_req), .call_pc(call_pc),
        .ret_req(ret_req),
        .irq_ack(irq_ack), .call_ack(call_ack),
        .ret_valid(ret_valid), .ret_addr(ret_addr),
        .stall(stall), .depth(depth),
        .stk_rst(stk_rst), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_din(stk_din), .stk_dout(stk_dout),
        .err_clr(err_clr), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    // call_stack model: registered write, registered read
    logic [15:0] mem [16];
    logic [3:0]  sp;
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        stk_dout = 16'h0;
    end
    always @(posedge clk) begin
        if (stk_rst) sp <= 4'd0;
        else if (stk_push) begin
            mem[sp] <= stk_din;
            sp      <= sp + 4'd1;
        end else if (stk_pop) begin
            stk_dout <= mem[sp - 4'd1];
            sp       <= sp - 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic run_ret(output logic [15:0] addr, output int lat);
        bit found = 1'b0;
        ret_req = 1'b1;
        lat = 0;
        addr = 16'hxxxx;
        @(negedge clk);
        chk("ret_stall0", stall, 1);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (ret_valid) begin
                addr = ret_addr;
                chk("ret_no_repop", stk_pop, 0);
                found = 1'b1;
                break;
            end
            lat++;
            nxt();
        end
        if (!found) begin
            chk("ret_timeout", 0, 1);
            lat = 99;
        end
        nxt();
        ret_req = 1'b0;
    endtask

    logic [15:0] a;
    int          lat;
    int          npush;

    initial begin
        rst_n = 1'b0;
        irq_req = 0; call_req = 0; ret_req = 0; err_clr = 0;
        irq_pc = 0; call_pc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_depth", depth, 0);
        chk("rst_stkrst", stk_rst, 1);
        chk("rst_stall", stall, 0);
        chk("rst_rvalid", ret_valid, 0);
        chk("rst_raddr", ret_addr, 0);
        chk("rst_push", stk_push, 0);

        // 1: CALL then RET from IDLE
        nxt();
        rst_n = 1'b1;
        call_req = 1'b1;
        call_pc = 16'h1234;
        @(negedge clk);
        chk("t1_stkrst_hold", stk_rst, 1);
        chk("t1_no_ack_rst", call_ack, 0);
        chk("t1_stall_rst", stall, 1);
        nxt();
        @(negedge clk);
        chk("t1_ack", call_ack, 1);
        chk("t1_push", stk_push, 1);
        chk("t1_din", stk_din, 16'h1234);
        nxt();
        call_req = 1'b0;
        @(negedge clk);
        chk("t1_depth1", depth, 1);
        chk("t1_stkrst_low", stk_rst, 0);
        nxt();
        nxt();
        run_ret(a, lat);
        chk("t1_raddr", a, 16'h1234);
        chk("t1_lat", lat, 2);
        @(negedge clk);
        chk("t1_depth0", depth, 0);

        // 2: RET landing in GAP
        nxt();
        call_req = 1'b1;
        call_pc = 16'hABCD;
        @(negedge clk);
        chk("t2_ack", call_ack, 1);
        nxt();
        call_req = 1'b0;
        run_ret(a, lat);
        chk("t2_raddr", a, 16'hABCD);
        chk("t2_lat", lat, 3);

        // 3: irq beats call
        irq_req = 1'b1; irq_pc = 16'h0010;
        call_req = 1'b1; call_pc = 16'h0200;
        @(negedge clk);
        chk("t3_irq_ack", irq_ack, 1);
        chk("t3_call_wait", call_ack, 0);
        chk("t3_din_irq", stk_din, 16'h0010);
        chk("t3_stall", stall, 1);
        nxt();
        irq_req = 1'b0;
        @(negedge clk);
        chk("t3_call_ack", call_ack, 1);
        chk("t3_din_call", stk_din, 16'h0200);
        nxt();
        call_req = 1'b0;
        @(negedge clk);
        chk("t3_depth2", depth, 2);
        run_ret(a, lat);
        chk("t3_ret1", a, 16'h0200);
        run_ret(a, lat);
        chk("t3_ret2", a, 16'h0010);
        @(negedge clk);
        chk("t3_depth0", depth, 0);

        // 5: RET on empty stack
        nxt();
        ret_req = 1'b1;
        @(negedge clk);
`ifdef STACK_TRAP_EN
        chk("t5_no_pop", stk_pop, 0);
`else
        chk("t5_pop", stk_pop, 1);
`endif
        ret_req = 1'b0;
        run_ret(a, lat);
`ifdef STACK_TRAP_EN
        chk("t5_raddr0", a, 0);
        chk("t5_unf", unf_err, 1);
`else
        chk("t5_unf0", unf_err, 0);
`endif
        @(negedge clk);
        chk("t5_depth0", depth, 0);

        // 4: 17 back-to-back pushes
        call_req = 1'b1;
        npush = 0;
        for (int i = 0; i < 16; i++) begin
            call_pc = 16'h0100 + 16'(i);
            @(negedge clk);
            if (stk_push && call_ack) npush++;
            nxt();
        end
        chk("t4_npush", npush, 16);
        call_pc = 16'h0555;
        @(negedge clk);
        chk("t4_depth16", depth, 16);
        chk("t4_ack17", call_ack, 1);
`ifdef STACK_TRAP_EN
        chk("t4_no_push17", stk_push, 0);
`else
        chk("t4_push17", stk_push, 1);
`endif
        nxt();
        call_req = 1'b0;
        @(negedge clk);
        chk("t4_depth_sat", depth, 16);
`ifdef STACK_TRAP_EN
        chk("t4_ovf", ovf_err, 1);
        nxt();
        err_clr = 1'b1;
        nxt();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_ovf_clr", ovf_err, 0);
        chk("t4_unf_clr", unf_err, 0);
        run_ret(a, lat);
        chk("t4_top", a, 16'h010F);
`else
        chk("t4_ovf0", ovf_err, 0);
        nxt();
        run_ret(a, lat);
`endif
        @(negedge clk);
        chk("t4_depth15", depth, 15);

        // 6: reset in RDATA
        nxt();
        ret_req = 1'b1;
        @(negedge clk);
        chk("t6_pop", stk_pop, 1);
        nxt();
        rst_n = 1'b0;
        ret_req = 1'b0;
        @(negedge clk);
        chk("t6_depth0", depth, 0);
        chk("t6_stkrst", stk_rst, 1);
        for (int i = 0; i < 3; i++) begin
            nxt();
            @(negedge clk);
            chk("t6_no_rvalid", ret_valid, 0);
        end
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_stkrst_hold", stk_rst, 1);
        chk("t6_raddr0", ret_addr, 0);
        nxt();
        @(negedge clk);
        chk("t6_stkrst_low", stk_rst, 0);
        chk("t6_rvalid0", ret_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
